// File: rtl/key_scan_ctrl_if.sv
// key_scan_ctrl_if
// Change-event handshake between the key scanner and its consumer, which is
// the sequencer or the recorder.
//   ev_valid : master -> slave, a change event is pending
//   ev_code  : master -> slave, the IOs value carried by the event
//   ev_ready : slave -> master, the consumer accepts the event
interface key_scan_ctrl_if;
  logic       ev_valid;
  logic [9:0] ev_code;
  logic       ev_ready;

  modport master (output ev_valid, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_code, output ev_ready);
endinterface

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl
// Scan controller for a 3-octave x 7-key matrix.
// - Drives the octave rows one-hot and samples the seven columns.
// - Debounces whole scan frames.
// - Picks one pressed key and presents it in key_encoder format:
//     IOs[9:7] = octave one-hot
//     IOs[6:0] = key one-hot
// - Reports every change of IOs through a valid/ready event.
//
// Ports
//   clk_5MHz : system clock; all logic runs on the rising edge
//   rst      : synchronous reset, active-high
//   col_in   : key columns, active-high when pressed, already synchronised
//   row_sel  : one-hot octave drive (bit0 low, bit1 medium, bit2 high)
//   IOs      : selected key; all zeros when no key is pressed
//   ev       : change-event handshake (master side)
//
// Optional feature: define KEY_SCAN_GHOST_REJECT_EN to reject ghost frames.
// A ghost frame has three or more keys down and two rows sharing a column.
module key_scan_ctrl #(
  parameter int SETTLE_CYC      = 5000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk_5MHz,
  input  logic             rst,
  input  logic [6:0]       col_in,
  output logic [2:0]       row_sel,
  output logic [9:0]       IOs,
  key_scan_ctrl_if.master  ev
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [3:0]  DEB_MAX     = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, EVAL} state_t;

  state_t          r_state, w_state_next;
  logic [1:0]      r_row, w_row_next;
  logic [15:0]     r_cnt, w_cnt_next;
  logic [2:0]      r_row_sel, w_row_sel_next;
  logic [2:0][6:0] r_frame, r_prev, r_stable;
  logic [3:0]      r_match, w_match_upd;
  logic [9:0]      r_ios, w_sel;
  logic            r_ev_valid;
  logic [9:0]      r_ev_code;
  logic            w_ghost;
  logic [2:0]      w_row_any;
  logic [2:0][6:0] w_row_low;

  // Scan sequencing
  always_ff @(posedge clk_5MHz) begin
    if (rst) begin
      r_state   <= IDLE;
      r_row     <= 2'd0;
      r_cnt     <= 16'd0;
      r_row_sel <= 3'b000;
    end else begin
      r_state   <= w_state_next;
      r_row     <= w_row_next;
      r_cnt     <= w_cnt_next;
      r_row_sel <= w_row_sel_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_row_next     = r_row;
    w_cnt_next     = r_cnt;
    w_row_sel_next = 3'b000;
    case (r_state)
      IDLE: begin
        w_state_next = SETTLE;
        w_row_next   = 2'd0;
        w_cnt_next   = 16'd0;
      end
      SETTLE: begin
        if (r_cnt == SETTLE_LAST) w_state_next = SAMPLE;
        else                      w_cnt_next   = r_cnt + 16'd1;
      end
      SAMPLE: begin
        if (r_row == 2'd2) begin
          w_state_next = EVAL;
        end else begin
          w_state_next = SETTLE;
          w_row_next   = r_row + 2'd1;
          w_cnt_next   = 16'd0;
        end
      end
      EVAL: begin
        w_state_next = SETTLE;
        w_row_next   = 2'd0;
        w_cnt_next   = 16'd0;
      end
      default: w_state_next = IDLE;
    endcase
    // row_sel is registered, so it is decoded from the upcoming state. The
    // row is then driven through its SETTLE and SAMPLE cycles.
    if (w_state_next == SETTLE || w_state_next == SAMPLE)
      w_row_sel_next = 3'b001 << w_row_next;
  end

  // Frame debounce
  always_comb begin
    if (r_frame == r_prev) w_match_upd = (r_match >= DEB_MAX) ? DEB_MAX : r_match + 4'd1;
    else                   w_match_upd = 4'd1;
  end

`ifdef KEY_SCAN_GHOST_REJECT_EN
  always_comb begin
    w_ghost = ($countones(r_frame) >= 3) &&
              (|((r_frame[0] & r_frame[1]) | (r_frame[0] & r_frame[2]) | (r_frame[1] & r_frame[2])));
  end
`else
  always_comb w_ghost = 1'b0;
`endif

  always_ff @(posedge clk_5MHz) begin
    if (rst) begin
      r_frame  <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      r_match  <= 4'd0;
    end else begin
      if (r_state == SAMPLE) r_frame[r_row] <= col_in;
      if (r_state == EVAL) begin
        if (w_ghost) begin
          // A ghost frame breaks the run but does not become the new reference.
          r_match <= 4'd0;
        end else begin
          r_match <= w_match_upd;
          r_prev  <= r_frame;
          if (w_match_upd >= DEB_MAX) r_stable <= r_frame;
        end
      end
    end
  end

  // Key selection: the lowest active row wins. Inside that row, x & -x
  // isolates the lowest pressed column.
  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    assign w_row_any[gi] = |r_stable[gi];
    assign w_row_low[gi] = r_stable[gi] & (~r_stable[gi] + 7'd1);
  end

  always_comb begin
    w_sel = 10'd0;
    if      (w_row_any[0]) w_sel = {3'b001, w_row_low[0]};
    else if (w_row_any[1]) w_sel = {3'b010, w_row_low[1]};
    else if (w_row_any[2]) w_sel = {3'b100, w_row_low[2]};
  end

  // IOs and change event. A new change always overwrites the event, so the
  // latest value wins even if the consumer has not taken the previous one.
  always_ff @(posedge clk_5MHz) begin
    if (rst) begin
      r_ios      <= 10'd0;
      r_ev_valid <= 1'b0;
      r_ev_code  <= 10'd0;
    end else begin
      r_ios <= w_sel;
      if (w_sel != r_ios) begin
        r_ev_valid <= 1'b1;
        r_ev_code  <= w_sel;
      end else if (r_ev_valid && ev.ev_ready) begin
        r_ev_valid <= 1'b0;
      end
    end
  end

  assign row_sel     = r_row_sel;
  assign IOs         = r_ios;
  assign ev.ev_valid = r_ev_valid;
  assign ev.ev_code  = r_ev_code;

endmodule

// File: tb/tb_key_scan_ctrl.sv
module tb_key_scan_ctrl;
  localparam int S = 2;
  localparam int D = 2;
  localparam int F = 3 * (S + 1) + 1;

  logic       clk_5MHz = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] col_in;
  logic [2:0] row_sel;
  logic [9:0] IOs;
  key_scan_ctrl_if ev_if();

  always #5 clk_5MHz = ~clk_5MHz;

  key_scan_ctrl #(.SETTLE_CYC(S), .DEBOUNCE_FRAMES(D)) dut (
    .clk_5MHz(clk_5MHz),
    .rst     (rst),
    .col_in  (col_in),
    .row_sel (row_sel),
    .IOs     (IOs),
    .ev      (ev_if)
  );

  // Physical key matrix: the columns show the keys of whichever row is driven.
  logic [6:0] km [3];
  always @* begin
    if      (row_sel[0]) col_in = km[0];
    else if (row_sel[1]) col_in = km[1];
    else if (row_sel[2]) col_in = km[2];
    else                 col_in = 7'd0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  // Behavioural model. Frames are counted in edges since reset release. The
  // position inside a frame follows from the frame length alone.
  int         m_k;
  int         m_p;
  int         m_match;
  int         m_bits;
  int         m_rows_c;
  logic       m_same;
  logic       m_ghost;
  logic [6:0] m_frame [3];
  logic [6:0] m_prev [3];
  logic [6:0] m_stable [3];
  logic [9:0] m_ios, m_code, m_nxt;
  logic       m_valid;
  logic [2:0] m_row_sel;

  function automatic logic [9:0] sel_key(input logic [6:0] m [3]);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 7; c++)
        if (m[r][c]) return {3'(1 << r), 7'(1 << c)};
    return 10'd0;
  endfunction

  function automatic logic [2:0] rowsel_for(input int k);
    int p;
    if (k == 0) return 3'b000;
    p = (k - 1) % F;
    if (p < 3 * (S + 1)) return 3'(1 << (p / (S + 1)));
    return 3'b000;
  endfunction

  always @(posedge clk_5MHz) begin
    if (rst) begin
      m_k = 0;
      m_match = 0;
      m_ios = 10'd0;
      m_code = 10'd0;
      m_valid = 1'b0;
      m_row_sel = 3'b000;
      for (int r = 0; r < 3; r++) begin
        m_frame[r] = 7'd0;
        m_prev[r] = 7'd0;
        m_stable[r] = 7'd0;
      end
    end else begin
      // IOs follows the stable matrix as it stood before this edge.
      m_nxt = sel_key(m_stable);
      if (m_k > 0) begin
        m_p = (m_k - 1) % F;
        if (m_p < 3 * (S + 1) && (m_p % (S + 1)) == S) begin
          m_frame[m_p / (S + 1)] = km[m_p / (S + 1)];
        end else if (m_p == F - 1) begin
          m_same = 1'b1;
          m_bits = 0;
          m_ghost = 1'b0;
          for (int r = 0; r < 3; r++) begin
            if (m_frame[r] != m_prev[r]) m_same = 1'b0;
            m_bits += $countones(m_frame[r]);
          end
          for (int c = 0; c < 7; c++) begin
            m_rows_c = 0;
            for (int r = 0; r < 3; r++) if (m_frame[r][c]) m_rows_c++;
            if (m_rows_c >= 2) m_ghost = 1'b1;
          end
          m_ghost = m_ghost && (m_bits >= 3);
`ifndef KEY_SCAN_GHOST_REJECT_EN
          m_ghost = 1'b0;
`endif
          if (m_ghost) begin
            m_match = 0;
          end else begin
            m_match = m_same ? ((m_match + 1 > D) ? D : m_match + 1) : 1;
            m_prev = m_frame;
            if (m_match >= D) m_stable = m_frame;
          end
        end
      end
      if (m_nxt != m_ios) begin
        m_valid = 1'b1;
        m_code = m_nxt;
      end else if (m_valid && ev_if.ev_ready) begin
        $display("EVENT accepted code=%b", m_code);
        m_valid = 1'b0;
      end
      m_ios = m_nxt;
      m_k++;
      m_row_sel = rowsel_for(m_k);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk_5MHz) begin
    check("cyc_row_sel", {7'd0, row_sel}, {7'd0, m_row_sel});
    check("cyc_IOs", IOs, m_ios);
    check("cyc_ev_valid", {9'd0, ev_if.ev_valid}, {9'd0, m_valid});
    check("cyc_ev_code", ev_if.ev_code, m_code);
  end

  // Returns on the first cycle of a frame, when row_sel first shows 001
  task automatic next_frame();
    logic [2:0] prev;
    prev = row_sel;
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk_5MHz);
      if (row_sel == 3'b001 && prev == 3'b000) return;
      prev = row_sel;
    end
    n_checks++;
    n_fail++;
    $display("FAIL frame_wait_timeout row_sel=%b", row_sel);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) next_frame();
    repeat (2) @(negedge clk_5MHz);
  endtask

  task automatic accept();
    ev_if.ev_ready = 1'b1;
    @(negedge clk_5MHz);
    ev_if.ev_ready = 1'b0;
    check("accept_clears_valid", {9'd0, ev_if.ev_valid}, 10'd0);
  endtask

  initial begin
    for (int r = 0; r < 3; r++) km[r] = 7'd0;
    ev_if.ev_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk_5MHz);
    check("rst_row_sel", {7'd0, row_sel}, 10'd0);
    check("rst_IOs", IOs, 10'd0);
    check("rst_ev_valid", {9'd0, ev_if.ev_valid}, 10'd0);
    rst = 1'b0;
    @(negedge clk_5MHz);
    check("scan_row0", {7'd0, row_sel}, 10'b001);
    repeat (3) @(negedge clk_5MHz);
    check("scan_row1", {7'd0, row_sel}, 10'b010);
    repeat (3) @(negedge clk_5MHz);
    check("scan_row2", {7'd0, row_sel}, 10'b100);
    repeat (3) @(negedge clk_5MHz);
    check("scan_eval", {7'd0, row_sel}, 10'b000);

    // Low Do
    next_frame();
    km[0] = 7'b0000001;
    frames(4);
    check("lowdo_IOs", IOs, 10'b001_0000001);
    check("lowdo_valid", {9'd0, ev_if.ev_valid}, 10'd1);
    check("lowdo_code", ev_if.ev_code, 10'b001_0000001);
    repeat (20) @(negedge clk_5MHz);
    check("hold_valid", {9'd0, ev_if.ev_valid}, 10'd1);
    check("hold_code", ev_if.ev_code, 10'b001_0000001);
    accept();

    // Low Re with high Do; then release low Re
    next_frame();
    km[0] = 7'b0000010;
    km[2] = 7'b0000001;
    frames(4);
    check("lowre_IOs", IOs, 10'b001_0000010);
    accept();
    km[0] = 7'b0000000;
    frames(4);
    check("highdo_IOs", IOs, 10'b100_0000001);
    check("highdo_code", ev_if.ev_code, 10'b100_0000001);
    check("highdo_valid", {9'd0, ev_if.ev_valid}, 10'd1);
    accept();

    // Bounce on medium Re
    km[2] = 7'b0000000;
    frames(4);
    check("clear_IOs", IOs, 10'd0);
    accept();
    next_frame();
    km[1] = 7'b0000010;
    next_frame();
    km[1] = 7'b0000000;
    next_frame();
    km[1] = 7'b0000010;
    repeat (2) @(negedge clk_5MHz);
    check("bounce_IOs", IOs, 10'd0);
    check("bounce_no_event", {9'd0, ev_if.ev_valid}, 10'd0);
    frames(1);
    check("bounce_one_frame_IOs", IOs, 10'd0);
    frames(1);
    check("medre_IOs", IOs, 10'b010_0000010);
    check("medre_valid", {9'd0, ev_if.ev_valid}, 10'd1);

    // Release while the event is still pending: latest value wins
    km[1] = 7'b0000000;
    frames(4);
    check("release_IOs", IOs, 10'd0);
    check("release_valid", {9'd0, ev_if.ev_valid}, 10'd1);
    check("release_code", ev_if.ev_code, 10'd0);

    // Mid-frame reset with an event pending
    km[0] = 7'b0000001;
    frames(4);
    check("prerst_valid", {9'd0, ev_if.ev_valid}, 10'd1);
    next_frame();
    repeat (4) @(negedge clk_5MHz);
    rst = 1'b1;
    km[0] = 7'b0000000;
    @(negedge clk_5MHz);
    check("midrst_row_sel", {7'd0, row_sel}, 10'd0);
    check("midrst_IOs", IOs, 10'd0);
    check("midrst_valid", {9'd0, ev_if.ev_valid}, 10'd0);
    check("midrst_code", ev_if.ev_code, 10'd0);
    repeat (2) @(negedge clk_5MHz);
    rst = 1'b0;

    // Ghost pattern
    next_frame();
    km[0] = 7'b0000011;
    km[1] = 7'b0000001;
    frames(4);
`ifdef KEY_SCAN_GHOST_REJECT_EN
    check("ghost_IOs", IOs, 10'd0);
    check("ghost_valid", {9'd0, ev_if.ev_valid}, 10'd0);
`else
    check("ghost_IOs", IOs, 10'b001_0000001);
    check("ghost_valid", {9'd0, ev_if.ev_valid}, 10'd1);
`endif
    km[0] = 7'd0;
    km[1] = 7'd0;
    frames(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
